// File: rtl/lcd_spi_pkg.sv
// lcd_spi_pkg: shared types and constants for the ST7735 SPI transmitter.
// Holds the FSM state enum, the byte width and the data/command flag codes.
package lcd_spi_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT_HI,
      SHIFT_LO,
      HOLD
   } lcd_spi_state_t;

   localparam int   LCD_SPI_BITS = 8;
   localparam logic LCD_DC_CMD   = 1'b0;
   localparam logic LCD_DC_DATA  = 1'b1;

endpackage

// File: rtl/lcd_spi_tx.sv
// lcd_spi_tx: SPI mode-0 byte transmitter for the ST7735 panel, MSB first.
// Ports: clk, rst (sync, active high); tx_data/tx_dc/tx_valid/tx_ready upstream;
// lcd_sclk/lcd_mosi/lcd_cs_n/lcd_dc panel pins; busy while not IDLE.
// Macro LCD_SPI_TX_CS_BURST_EN: accept on the last HOLD cycle, keeping cs_n low.
module lcd_spi_tx
   import lcd_spi_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [LCD_SPI_BITS-1:0] tx_data,
   input  logic                    tx_dc,
   input  logic                    tx_valid,
   output logic                    tx_ready,
   output logic                    lcd_sclk,
   output logic                    lcd_mosi,
   output logic                    lcd_cs_n,
   output logic                    lcd_dc,
   output logic                    busy
);

   localparam logic [7:0] HC_LAST = 8'(CLK_DIV - 1);
   localparam logic [2:0] BI_TOP  = 3'(LCD_SPI_BITS - 1);

   lcd_spi_state_t          r_state;
   lcd_spi_state_t          w_state_n;
   logic [7:0]              r_hc;
   logic [7:0]              w_hc_n;
   logic [2:0]              r_bi;
   logic [2:0]              w_bi_n;
   logic [LCD_SPI_BITS-1:0] r_sh;
   logic [LCD_SPI_BITS-1:0] w_sh_n;
   logic                    r_dc;
   logic                    w_dc_n;
   logic                    r_live;
   logic                    r_sclk;
   logic                    r_mosi;
   logic                    r_cs_n;
   logic                    r_pdc;
   logic                    w_rdy;
   logic                    w_last;
   logic                    w_acc;

   assign w_last   = (r_hc == HC_LAST);
   assign w_acc    = tx_valid && w_rdy;
   assign tx_ready = w_rdy;
   assign busy     = (r_state != IDLE);
   assign lcd_sclk = r_sclk;
   assign lcd_mosi = r_mosi;
   assign lcd_cs_n = r_cs_n;
   assign lcd_dc   = r_pdc;

   always_comb begin
      w_state_n = r_state;
      w_hc_n    = w_last ? 8'd0 : r_hc + 8'd1;
      w_bi_n    = r_bi;
      w_sh_n    = r_sh;
      w_dc_n    = r_dc;
      w_rdy     = 1'b0;
      unique case (r_state)
         IDLE: begin
            w_hc_n = 8'd0;
            w_rdy  = r_live;
         end
         SETUP: begin
            if (w_last) w_state_n = SHIFT_HI;
         end
         SHIFT_HI: begin
            if (w_last) begin
               if (r_bi != 3'd0) begin
                  w_sh_n    = {r_sh[LCD_SPI_BITS-2:0], 1'b0};
                  w_bi_n    = r_bi - 3'd1;
                  w_state_n = SHIFT_LO;
               end else begin
                  w_state_n = HOLD;
               end
            end
         end
         SHIFT_LO: begin
            if (w_last) w_state_n = SHIFT_HI;
         end
         HOLD: begin
`ifdef LCD_SPI_TX_CS_BURST_EN
            w_rdy = w_last;
`endif
            if (w_last) w_state_n = IDLE;
         end
         default: w_state_n = IDLE;
      endcase
      if (w_acc) begin
         w_state_n = SETUP;
         w_hc_n    = 8'd0;
         w_bi_n    = BI_TOP;
         w_sh_n    = tx_data;
         w_dc_n    = tx_dc;
      end
   end

   // Pins are registered from the current state, so they trail the FSM
   // by one cycle; this gives the extra cycle between accept and cs_n low.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_hc    <= 8'd0;
         r_bi    <= 3'd0;
         r_sh    <= '0;
         r_dc    <= LCD_DC_CMD;
         r_live  <= 1'b0;
         r_sclk  <= 1'b0;
         r_mosi  <= 1'b0;
         r_cs_n  <= 1'b1;
         r_pdc   <= LCD_DC_CMD;
      end else begin
         r_state <= w_state_n;
         r_hc    <= w_hc_n;
         r_bi    <= w_bi_n;
         r_sh    <= w_sh_n;
         r_dc    <= w_dc_n;
         r_live  <= 1'b1;
         r_sclk  <= (r_state == SHIFT_HI);
         r_mosi  <= r_sh[LCD_SPI_BITS-1];
         r_cs_n  <= (r_state == IDLE);
         r_pdc   <= r_dc;
      end
   end

endmodule
